cordic_iter_engine: RTL and testbench
=====================================

Name: cordic_iter_engine

Overview:
- Self-contained iterative CORDIC engine: control path and datapath in one block, parametrised in data width and iteration count.
- Supports rotation mode (compute x·cos/sin of an angle) and vectoring mode (compute magnitude and atan2).
- Valid/ready handshakes on both sides replace bare start/done, so it sits directly between streaming producers and consumers in the DSP path.
- One transaction in flight at a time.

Parameters:
- WIDTH, 16: signed input width of x_in/y_in.
- ITERS, 14: number of micro-rotations, 1..WIDTH.
- ANGLE_WIDTH, 16: signed angle width in binary radians; 2^(ANGLE_WIDTH-1) = pi.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  input transaction valid.
- in_ready  out  1  engine can accept a transaction.
- mode  in  1  0 = rotation, 1 = vectoring; sampled at accept.
- x_in  in  WIDTH  signed x.
- y_in  in  WIDTH  signed y.
- z_in  in  ANGLE_WIDTH  signed angle.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- x_out  out  WIDTH+2  signed x result, CORDIC gain ~1.6468 uncompensated.
- y_out  out  WIDTH+2  signed y result.
- z_out  out  ANGLE_WIDTH  signed residual angle (rotation) or accumulated angle (vectoring).
- busy  out  1  high in COMPUTE or HOLD.

Behaviour:
- States: IDLE, COMPUTE, HOLD. Reset value is IDLE.
- While reset is asserted: all registers clear to 0 and out_valid=0. in_ready is forced to 0 while reset is asserted and equals (state==IDLE) otherwise.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: sign-extend x_in/y_in into WIDTH+2-bit x/y registers, load z, latch mode, clear iteration counter i, go to COMPUTE.
- COMPUTE:
  - Iteration i executes at edge T+1+i for i = 0..ITERS-1.
  - Direction d = +1 in rotation when z>=0; d = +1 in vectoring when y<0; d = -1 otherwise.
  - Update: x' = x - d·(y>>>i), y' = y + d·(x>>>i), z' = z - d·atan_lut[i]. Shifts are arithmetic; z arithmetic wraps modulo 2^ANGLE_WIDTH.
  - After the iteration with i==ITERS-1, go to HOLD.
- HOLD:
  - out_valid=1; outputs are driven directly from the registers and stay stable.
  - in_valid is ignored (in_ready=0).
  - On out_ready, go to IDLE at that edge.
- Latency: out_valid rises ITERS cycles after the accept edge.
- Throughput with out_ready tied high: one transaction per ITERS+2 cycles. There is no same-cycle IDLE bypass.
- atan_lut[i] = round(atan(2^-i)/pi · 2^(ANGLE_WIDTH-1)). For ANGLE_WIDTH=16, atan_lut[0]=8192.
- Without quadrant correction, valid input range is |z| <= ~99.7° in rotation and x_in >= 0 in vectoring. Outside that range results are unspecified but the engine must still complete and handshake normally.
- Asynchronous reset mid-COMPUTE or mid-HOLD aborts the transaction with no output. The first accept after reset release behaves as a fresh transaction.
- mode and inputs changing during COMPUTE have no effect.

Optional Feature:
- Macro: CORDIC_QUAD_CORR_EN.
- Defined: a pre-rotation is applied on the accept edge, with no added latency.
  - Rotation: if z_in is outside [-pi/2, pi/2) (top two bits differ), load x=-x_in, y=-y_in, z=z_in+pi (wrapping).
  - Vectoring: if x_in<0, load x=-x_in, y=-y_in, z=z_in+pi.
  - Gives full ±pi coverage.
- Undefined: inputs are loaded unmodified; the range restrictions above apply.

Decomposition:
- Package cordic_pkg holds:
  - the state enum typedef;
  - MAX_ITERS=32;
  - constant function atan_entry(i, angle_width) generating the LUT;
  - CORDIC_GAIN_Q15 = 19898 (1/K scaled by 2^15).
- Natural sub-module: cordic_micro_rot, a combinational single-iteration x/y/z update taking shift index, direction and LUT value. The top level owns the FSM, counter and registers.

Test Plan (WIDTH=16, ITERS=14, ANGLE_WIDTH=16):
- Rotation: x=19898, y=0, z=8192 (45°) -> x_out≈23170, y_out≈23170 within ±4 LSB; z_out within ±4; out_valid rises 14 cycles after accept.
- Vectoring: x=10000, y=10000, z=0 -> z_out≈8192 ±2, x_out≈23289 ±4, y_out≈0 ±4.
- Back-pressure: out_ready held low for 5 cycles in HOLD -> outputs stable, in_ready=0, a pulsed in_valid is not accepted; release -> IDLE and next accept 1 cycle later.
- Back-to-back: two transactions with out_ready=1 -> accepts spaced exactly 16 cycles apart; both results correct.
- Reset asserted at iteration 3 -> out_valid=0 immediately, busy=0; in_ready high on the first cycle after release; a following 45° rotation gives correct results.
- With CORDIC_QUAD_CORR_EN: x=19898, y=0, z=24576 (135°) -> x_out≈-23170, y_out≈23170 ±4; vectoring with x=-10000, y=0 -> z_out≈-32768 (pi, wrapped), x_out≈16468 ±4.

Source files
------------

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared types and constants for the iterative CORDIC engine:
//                FSM state encoding, iteration limit, arctangent table
//                generator and the reciprocal CORDIC gain.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    // Engine control states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_HOLD    = 2'd2
    } cordic_state_t;

    // Upper bound on micro-rotations; sizes the counter and the LUT
    localparam int MAX_ITERS = 32;

    // 1/K scaled by 2^15 (K ~ 1.6468), for consumers that compensate the gain
    localparam int CORDIC_GAIN_Q15 = 19898;

    // atan(2^-i) in binary radians, rounded to angle_width bits (pi = 2^(aw-1)).
    // The base table holds the values at 32-bit resolution (pi = 2^31) and is
    // rounded down to the requested width.
    function automatic logic [31:0] atan_entry(input int i, input int angle_width);
        logic [31:0] full;
        logic [32:0] rnd;
        case (i)
            0:  full = 32'h2000_0000;
            1:  full = 32'h12E4_051E;
            2:  full = 32'h09FB_385B;
            3:  full = 32'h0511_11D4;
            4:  full = 32'h028B_0D43;
            5:  full = 32'h0145_D7E1;
            6:  full = 32'h00A2_F61E;
            7:  full = 32'h0051_7C55;
            8:  full = 32'h0028_BE53;
            9:  full = 32'h0014_5F2F;
            10: full = 32'h000A_2F98;
            11: full = 32'h0005_17CC;
            12: full = 32'h0002_8BE6;
            13: full = 32'h0001_45F3;
            14: full = 32'h0000_A2FA;
            15: full = 32'h0000_517D;
            16: full = 32'h0000_28BE;
            17: full = 32'h0000_145F;
            18: full = 32'h0000_0A30;
            19: full = 32'h0000_0518;
            20: full = 32'h0000_028C;
            21: full = 32'h0000_0146;
            22: full = 32'h0000_00A3;
            23: full = 32'h0000_0051;
            24: full = 32'h0000_0029;
            25: full = 32'h0000_0014;
            26: full = 32'h0000_000A;
            27: full = 32'h0000_0005;
            28: full = 32'h0000_0003;
            29: full = 32'h0000_0001;
            30: full = 32'h0000_0001;
            default: full = 32'h0000_0000;
        endcase
        if (angle_width >= 32) begin
            return full;
        end
        rnd = {1'b0, full} + (33'd1 << (31 - angle_width));
        return 32'(rnd >> (32 - angle_width));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_micro_rot.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_micro_rot
//  Description : Combinational single CORDIC micro-rotation. Applies one
//                shift-and-add step to x/y and steps the angle accumulator
//                by the supplied arctangent value in the chosen direction.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_micro_rot #(
    parameter int XW = 18,
    parameter int AW = 16,
    parameter int SW = 5
) (
    input  logic signed [XW-1:0] i_x,
    input  logic signed [XW-1:0] i_y,
    input  logic signed [AW-1:0] i_z,
    input  logic        [SW-1:0] i_shift,
    input  logic                 i_dir_pos,
    input  logic        [AW-1:0] i_atan,
    output logic signed [XW-1:0] o_x,
    output logic signed [XW-1:0] o_y,
    output logic signed [AW-1:0] o_z
);

    logic signed [XW-1:0] w_x_sh;
    logic signed [XW-1:0] w_y_sh;
    logic signed [AW-1:0] w_atan;

    // Arithmetic shifts keep the sign of negative operands (floor division)
    assign w_x_sh = i_x >>> i_shift;
    assign w_y_sh = i_y >>> i_shift;
    assign w_atan = $signed(i_atan);

    // Rotate by +atan(2^-i) when d=+1, by -atan(2^-i) otherwise; z wraps freely
    always_comb begin
        if (i_dir_pos) begin
            o_x = i_x - w_y_sh;
            o_y = i_y + w_x_sh;
            o_z = i_z - w_atan;
        end else begin
            o_x = i_x + w_y_sh;
            o_y = i_y - w_x_sh;
            o_z = i_z + w_atan;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_iter_engine.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_iter_engine
//  Description : Iterative CORDIC engine, rotation and vectoring modes, one
//                micro-rotation per clock, valid/ready on both sides, one
//                transaction in flight. Results carry the uncompensated
//                CORDIC gain (~1.6468).
//                Build option CORDIC_QUAD_CORR_EN: pre-rotate by pi on the
//                accept edge for full +/-pi coverage.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int ITERS       = 14,
    parameter int ANGLE_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          mode,
    input  logic signed [WIDTH-1:0]       x_in,
    input  logic signed [WIDTH-1:0]       y_in,
    input  logic signed [ANGLE_WIDTH-1:0] z_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WIDTH+1:0]       x_out,
    output logic signed [WIDTH+1:0]       y_out,
    output logic signed [ANGLE_WIDTH-1:0] z_out,
    output logic                          busy
);

    localparam int              c_XW   = WIDTH + 2;
    localparam int              c_IW   = $clog2(MAX_ITERS);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(ITERS - 1);

    cordic_state_t              r_state;
    cordic_state_t              w_next_state;
    logic                       r_mode;
    logic signed [c_XW-1:0]        r_x;
    logic signed [c_XW-1:0]        r_y;
    logic signed [ANGLE_WIDTH-1:0] r_z;
    logic        [c_IW-1:0]        r_iter;

    logic                          w_accept;
    logic signed [c_XW-1:0]        w_x_ext;
    logic signed [c_XW-1:0]        w_y_ext;
    logic signed [c_XW-1:0]        w_x_load;
    logic signed [c_XW-1:0]        w_y_load;
    logic signed [ANGLE_WIDTH-1:0] w_z_load;
    logic                          w_dir_pos;
    logic        [ANGLE_WIDTH-1:0] w_atan;
    logic signed [c_XW-1:0]        w_x_nxt;
    logic signed [c_XW-1:0]        w_y_nxt;
    logic signed [ANGLE_WIDTH-1:0] w_z_nxt;

    // Arctangent table, one entry per possible counter value (unused tail = 0)
    logic [ANGLE_WIDTH-1:0] w_lut [MAX_ITERS];

    for (genvar gi = 0; gi < MAX_ITERS; gi++) begin : g_lut
        if (gi < ITERS) begin : g_used
            assign w_lut[gi] = ANGLE_WIDTH'(atan_entry(gi, ANGLE_WIDTH));
        end else begin : g_unused
            assign w_lut[gi] = '0;
        end
    end

    assign w_atan   = w_lut[r_iter];
    assign w_accept = in_valid && in_ready;

    // Two guard bits absorb the CORDIC gain growth
    assign w_x_ext = {{2{x_in[WIDTH-1]}}, x_in};
    assign w_y_ext = {{2{y_in[WIDTH-1]}}, y_in};

`ifdef CORDIC_QUAD_CORR_EN
    logic w_flip;

    // Fold inputs into the convergent half-plane by a rotation of pi
    always_comb begin
        w_flip   = mode ? w_x_ext[c_XW-1]
                        : (z_in[ANGLE_WIDTH-1] ^ z_in[ANGLE_WIDTH-2]);
        w_x_load = w_x_ext;
        w_y_load = w_y_ext;
        w_z_load = z_in;
        if (w_flip) begin
            w_x_load = -w_x_ext;
            w_y_load = -w_y_ext;
            w_z_load = {~z_in[ANGLE_WIDTH-1], z_in[ANGLE_WIDTH-2:0]};
        end
    end
`else
    assign w_x_load = w_x_ext;
    assign w_y_load = w_y_ext;
    assign w_z_load = z_in;
`endif

    // Rotation drives z toward 0, vectoring drives y toward 0
    assign w_dir_pos = r_mode ? r_y[c_XW-1] : ~r_z[ANGLE_WIDTH-1];

    cordic_micro_rot #(
        .XW (c_XW),
        .AW (ANGLE_WIDTH),
        .SW (c_IW)
    ) u_micro_rot (
        .i_x       (r_x),
        .i_y       (r_y),
        .i_z       (r_z),
        .i_shift   (r_iter),
        .i_dir_pos (w_dir_pos),
        .i_atan    (w_atan),
        .o_x       (w_x_nxt),
        .o_y       (w_y_nxt),
        .o_z       (w_z_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: accept -> iterate ITERS times -> hold until consumed
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept)         w_next_state = ST_COMPUTE;
            ST_COMPUTE: if (r_iter == c_LAST) w_next_state = ST_HOLD;
            ST_HOLD:    if (out_ready)        w_next_state = ST_IDLE;
            default:                          w_next_state = ST_IDLE;
        endcase
    end

    // Handshake and status outputs; in_ready is held low during reset
    always_comb begin
        in_ready  = reset && (r_state == ST_IDLE);
        out_valid = (r_state == ST_HOLD);
        busy      = (r_state != ST_IDLE);
    end

    // Datapath: load on accept, one micro-rotation per cycle while computing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_iter <= '0;
        end else if (w_accept) begin
            r_mode <= mode;
            r_x    <= w_x_load;
            r_y    <= w_y_load;
            r_z    <= w_z_load;
            r_iter <= '0;
        end else if (r_state == ST_COMPUTE) begin
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_z    <= w_z_nxt;
            r_iter <= r_iter + c_IW'(1);
        end
    end

    assign x_out = r_x;
    assign y_out = r_y;
    assign z_out = r_z;

endmodule
`default_nettype wire

// File: tb/tb_cordic_iter_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_iter_engine
//  Description : Directed self-checking bench for cordic_iter_engine
//                (WIDTH=16, ITERS=14, ANGLE_WIDTH=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_iter_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic               mode;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic signed [15:0] z_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [17:0] x_out;
    logic signed [17:0] y_out;
    logic signed [15:0] z_out;
    logic               busy;

    int n_pass  = 0;
    int n_total = 0;

    cordic_iter_engine #(
        .WIDTH       (16),
        .ITERS       (14),
        .ANGLE_WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .busy      (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        n_total++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Angle compare modulo 2^16
    task automatic chk_ang(input string tag, input logic signed [15:0] obs, input int exp, input int tol);
        logic signed [15:0] d;
        d = obs - 16'(exp);
        n_total++;
        assert (int'(d) <= tol && int'(d) >= -tol) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (tol %0d, mod 2^16)", tag, obs, exp, tol);
    endtask

    // Offer one transaction at a negedge; returns edges from accept to out_valid
    task automatic send(input logic m, input int x, input int y, input int z, output int lat);
        @(negedge clk);
        mode     = m;
        x_in     = 16'(x);
        y_in     = 16'(y);
        z_in     = 16'(z);
        in_valid = 1'b1;
        chk_bit("in_ready_at_offer", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        int na;
        int nr;
        int pend;
        int acc [2];
        int rx  [2];
        int ry  [2];
        int rz  [2];
        logic signed [17:0] cap_x;
        logic signed [17:0] cap_y;
        logic signed [15:0] cap_z;

        reset     = 1'b0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_in_ready", in_ready, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk("rst_x_out", int'(x_out), 0, 0);
        reset = 1'b1;
        @(negedge clk);
        chk_bit("idle_in_ready", in_ready, 1'b1);

        // Rotation by 45 degrees of (19898, 0)
        send(1'b0, 19898, 0, 8192, lat);
        chk("rot_latency", lat, 14, 0);
        chk("rot_x", int'(x_out), 23170, 4);
        chk("rot_y", int'(y_out), 23170, 4);
        chk_ang("rot_z", z_out, 0, 4);
        chk_bit("rot_busy_hold", busy, 1'b1);
        @(negedge clk);
        chk_bit("rot_back_idle_valid", out_valid, 1'b0);
        chk_bit("rot_back_idle_ready", in_ready, 1'b1);

        // Vectoring of (10000, 10000)
        send(1'b1, 10000, 10000, 0, lat);
        chk("vec_latency", lat, 14, 0);
        chk("vec_x", int'(x_out), 23289, 4);
        chk("vec_y", int'(y_out), 0, 4);
        chk_ang("vec_z", z_out, 8192, 2);
        @(negedge clk);

        // Back-pressure: hold for 5 cycles, pulse in_valid once
        out_ready = 1'b0;
        send(1'b0, 19898, 0, 8192, lat);
        chk_bit("bp_valid", out_valid, 1'b1);
        cap_x = x_out;
        cap_y = y_out;
        cap_z = z_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                mode     = 1'b1;
                x_in     = 16'sd1234;
                y_in     = 16'sd999;
                z_in     = 16'sd100;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            chk_bit("bp_hold_valid", out_valid, 1'b1);
            chk_bit("bp_hold_ready", in_ready, 1'b0);
            chk("bp_x_stable", int'(x_out), int'(cap_x), 0);
            chk("bp_y_stable", int'(y_out), int'(cap_y), 0);
            chk("bp_z_stable", int'(z_out), int'(cap_z), 0);
        end
        chk("bp_x_value", int'(x_out), 23170, 4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk_bit("bp_release_valid", out_valid, 1'b0);
        chk_bit("bp_release_ready", in_ready, 1'b1);
        chk_bit("bp_release_busy", busy, 1'b0);

        // Back-to-back: rotation then vectoring, out_ready tied high
        acc[0] = 0; acc[1] = 0;
        rx[0] = 0; rx[1] = 0; ry[0] = 0; ry[1] = 0; rz[0] = 0; rz[1] = 0;
        na = 0;
        nr = 0;
        pend = 0;
        mode     = 1'b0;
        x_in     = 16'sd19898;
        y_in     = 16'sd0;
        z_in     = 16'sd8192;
        in_valid = 1'b1;
        k = 0;
        while (k < 80 && nr < 2) begin
            if (pend != 0) begin
                if (na == 1) begin
                    mode = 1'b1;
                    x_in = 16'sd10000;
                    y_in = 16'sd10000;
                    z_in = 16'sd0;
                end else begin
                    in_valid = 1'b0;
                end
                pend = 0;
            end
            if (in_ready && in_valid && na < 2) begin
                acc[na] = k;
                na++;
                pend = 1;
            end
            if (out_valid && nr < 2) begin
                rx[nr] = int'(x_out);
                ry[nr] = int'(y_out);
                rz[nr] = int'(z_out);
                nr++;
            end
            if (nr < 2) begin
                @(negedge clk);
                k++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_spacing", acc[1] - acc[0], 16, 0);
        chk("b2b_rot_x", rx[0], 23170, 4);
        chk("b2b_rot_y", ry[0], 23170, 4);
        chk("b2b_vec_x", rx[1], 23289, 4);
        chk_ang("b2b_vec_z", 16'(rz[1]), 8192, 2);

        // Reset asserted while iteration 3 is pending
        @(negedge clk);
        mode     = 1'b0;
        x_in     = 16'sd19898;
        y_in     = 16'sd0;
        z_in     = 16'sd8192;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_bit("mid_rst_out_valid", out_valid, 1'b0);
        chk_bit("mid_rst_busy", busy, 1'b0);
        chk_bit("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_x_clear", int'(x_out), 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_bit("post_rst_in_ready", in_ready, 1'b1);
        send(1'b0, 19898, 0, 8192, lat);
        chk("post_rst_latency", lat, 14, 0);
        chk("post_rst_x", int'(x_out), 23170, 4);
        chk("post_rst_y", int'(y_out), 23170, 4);
        chk_ang("post_rst_z", z_out, 0, 4);
        @(negedge clk);

`ifdef CORDIC_QUAD_CORR_EN
        // Rotation by 135 degrees needs the pi pre-rotation
        send(1'b0, 19898, 0, 24576, lat);
        chk("quad_rot_latency", lat, 14, 0);
        chk("quad_rot_x", int'(x_out), -23170, 4);
        chk("quad_rot_y", int'(y_out), 23170, 4);
        @(negedge clk);

        // Vectoring of a negative-x point lands at pi
        send(1'b1, -10000, 0, 0, lat);
        chk("quad_vec_x", int'(x_out), 16468, 4);
        chk_ang("quad_vec_z", z_out, -32768, 4);
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
